// File: rtl/popcount_stream_acc_if.sv
// Valid/ready stream bundle for popcount_stream_acc: word input channel and
// per-word count/frame-total result channel.
interface popcount_stream_acc_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 16
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_mode;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_cnt;
  logic [ACC_W-1:0]  out_acc;
  logic              out_last;
  logic              out_sat;

  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_cnt, out_acc, out_last, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_cnt, out_acc, out_last, out_sat
  );
endinterface

// File: rtl/popcount_stream_acc.sv
// Two-stage streaming popcount: byte-lane counts in stage 1, word sum plus
// saturating per-frame running total in stage 2. Whole pipe stalls as one.
module popcount_stream_acc #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  popcount_stream_acc_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int NL    = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 256 || ACC_W < CNT_W) begin : g_param_err
    $error("popcount_stream_acc: illegal DATA_W/ACC_W combination");
  end

  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < 8; k++) c = c + {3'b000, b[k]};
    return c;
  endfunction

  logic              en;
  logic [DATA_W-1:0] data_sel;

  logic              v1_q;
  logic              last1_q;
  logic [NL-1:0][3:0] lane_d, lane_q;

  logic              out_valid_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [ACC_W-1:0]  out_acc_q;
  logic              out_last_q;
  logic              out_sat_q;
  logic              frame_start_q;

  logic [CNT_W-1:0]  cnt_d;
  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum_w;
  logic              ovf;
  logic [ACC_W-1:0]  acc_d;
  logic              sat_d;

  // in_ready depends only on the output register and out_ready, never on in_valid
  assign en          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = en;
  assign data_sel    = bus.in_mode ? ~bus.in_data : bus.in_data;

  always_comb begin
    lane_d = '0;
    for (int l = 0; l < NL; l++) lane_d[l] = pop8(data_sel[l*8 +: 8]);
  end

  always_comb begin
    cnt_d = '0;
    for (int l = 0; l < NL; l++) cnt_d = cnt_d + CNT_W'(lane_q[l]);
  end

  // ACC_W >= CNT_W guarantees base+cnt fits in ACC_W+1 bits, so the top bit
  // alone flags overflow past the saturation ceiling.
  always_comb begin
    base  = frame_start_q ? '0 : out_acc_q;
    sum_w = {1'b0, base} + (ACC_W + 1)'(cnt_d);
    ovf   = sum_w[ACC_W];
    acc_d = ovf ? '1 : sum_w[ACC_W-1:0];
    sat_d = ovf | (~frame_start_q & out_sat_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      lane_q  <= '0;
    end else if (en) begin
      v1_q    <= bus.in_valid;
      last1_q <= bus.in_last;
      lane_q  <= lane_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_cnt_q     <= '0;
      out_acc_q     <= '0;
      out_last_q    <= 1'b0;
      out_sat_q     <= 1'b0;
      frame_start_q <= 1'b1;
    end else if (en) begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_cnt_q     <= cnt_d;
        out_acc_q     <= acc_d;
        out_last_q    <= last1_q;
        out_sat_q     <= sat_d;
        frame_start_q <= last1_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Directed bench for popcount_stream_acc: a default instance (ACC_W=16) and a
// narrow-accumulator instance (ACC_W=8) for saturation.
module tb_popcount_stream_acc;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  popcount_stream_acc_if #(.DATA_W(32), .ACC_W(16)) ifa ();
  popcount_stream_acc_if #(.DATA_W(32), .ACC_W(8))  ifb ();

  popcount_stream_acc #(.DATA_W(32), .ACC_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  popcount_stream_acc #(.DATA_W(32), .ACC_W(8))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d, input logic m, input logic l);
    ifa.in_valid = v; ifa.in_data = d; ifa.in_mode = m; ifa.in_last = l;
    tick();
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic m, input logic l);
    ifb.in_valid = v; ifb.in_data = d; ifb.in_mode = m; ifb.in_last = l;
    tick();
  endtask

  task automatic out_a(input string tag, input logic v, input int cnt, input int acc,
                       input logic last, input logic sat);
    chk({tag, "_valid"}, 32'(ifa.out_valid), 32'(v));
    chk({tag, "_cnt"},   32'(ifa.out_cnt),   cnt);
    chk({tag, "_acc"},   32'(ifa.out_acc),   acc);
    chk({tag, "_last"},  32'(ifa.out_last),  32'(last));
    chk({tag, "_sat"},   32'(ifa.out_sat),   32'(sat));
  endtask

  int   sat_cnt [10] = '{32, 32, 32, 32, 32, 32, 32, 32, 32, 2};
  int   sat_acc [10] = '{32, 64, 96, 128, 160, 192, 224, 255, 255, 2};
  logic sat_sat [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   got, k, stall;
    logic seen, acc_now;

    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_mode = 0; ifa.in_last = 0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.in_mode = 0; ifb.in_last = 0; ifb.out_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    out_a("reset", 0, 0, 0, 0, 0);
    chk("reset_in_ready", 32'(ifa.in_ready), 1);
    #2 rst_n = 1;
    tick();

    // mode 0 frame, result appears two cycles after the word is presented
    drive_a(1, 32'h0000_0000, 0, 0); out_a("m0_c1", 0, 0, 0, 0, 0);
    drive_a(1, 32'hFFFF_FFFF, 0, 0); out_a("m0_w0", 1, 0, 0, 0, 0);
    drive_a(1, 32'h0000_F00F, 0, 1); out_a("m0_w1", 1, 32, 32, 0, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("m0_w2", 1, 8, 40, 1, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("m0_idle", 0, 8, 40, 1, 0);

    // mode 1 frame
    drive_a(1, 32'h0000_0000, 1, 0); out_a("m1_c1", 0, 8, 40, 1, 0);
    drive_a(1, 32'hFFFF_FFFF, 1, 0); out_a("m1_w0", 1, 32, 32, 0, 0);
    drive_a(1, 32'h0000_F00F, 1, 1); out_a("m1_w1", 1, 0, 32, 0, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("m1_w2", 1, 24, 56, 1, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("m1_idle", 0, 24, 56, 1, 0);

    // back-pressure: six words of 0x1, consumer stalls 4 cycles at first result
    got = 0; k = 0; stall = 0; seen = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (ifa.out_valid && !seen) begin
        seen  = 1;
        stall = 4;
      end
      ifa.out_ready = (stall == 0);
      ifa.in_valid  = (k < 6);
      ifa.in_data   = 32'h1;
      ifa.in_mode   = 0;
      ifa.in_last   = (k == 5);
      #1;
      if (stall > 0) begin
        chk("bp_stall_in_ready", 32'(ifa.in_ready), 0);
        chk("bp_stall_valid", 32'(ifa.out_valid), 1);
        chk("bp_stall_cnt", 32'(ifa.out_cnt), 1);
        chk("bp_stall_acc", 32'(ifa.out_acc), 1);
        stall--;
      end
      acc_now = ifa.in_valid & ifa.in_ready;
      if (ifa.out_valid && ifa.out_ready) begin
        got++;
        chk("bp_cnt", 32'(ifa.out_cnt), 1);
        chk("bp_acc", 32'(ifa.out_acc), got);
        chk("bp_last", 32'(ifa.out_last), 32'(got == 6));
      end
      tick();
      if (acc_now) k++;
    end
    chk("bp_delivered", got, 6);
    chk("bp_accepted", k, 6);
    ifa.out_ready = 1;
    drive_a(0, 32'h0, 0, 0);
    drive_a(0, 32'h0, 0, 0);
    out_a("bp_drained", 0, 1, 6, 1, 0);

    // single-word frame, three idle cycles, then a two-word frame
    drive_a(1, 32'h0000_00FF, 0, 1); out_a("bub_c0", 0, 1, 6, 1, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("bub_a", 1, 8, 8, 1, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("bub_g1", 0, 8, 8, 1, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("bub_g2", 0, 8, 8, 1, 0);
    drive_a(1, 32'h1, 0, 0);         out_a("bub_g3", 0, 8, 8, 1, 0);
    drive_a(1, 32'h1, 0, 1);         out_a("bub_b0", 1, 1, 1, 0, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("bub_b1", 1, 1, 2, 1, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("bub_end", 0, 1, 2, 1, 0);

    // saturation on the 8-bit accumulator instance
    for (int c = 0; c < 12; c++) begin
      if (c < 9)       drive_b(1, 32'hFFFF_FFFF, 0, (c == 8));
      else if (c == 9) drive_b(1, 32'h0000_0003, 0, 1);
      else             drive_b(0, 32'h0, 0, 0);
      if (c >= 1 && c <= 10) begin
        chk("sat_valid", 32'(ifb.out_valid), 1);
        chk("sat_cnt",   32'(ifb.out_cnt),   sat_cnt[c-1]);
        chk("sat_acc",   32'(ifb.out_acc),   sat_acc[c-1]);
        chk("sat_flag",  32'(ifb.out_sat),   32'(sat_sat[c-1]));
        chk("sat_last",  32'(ifb.out_last),  32'((c - 1) >= 8));
      end
    end
    chk("sat_idle_valid", 32'(ifb.out_valid), 0);

    // asynchronous reset with two words in flight, partial frame discarded
    drive_a(1, 32'h0000_00FF, 0, 0); out_a("rst_c0", 0, 1, 2, 1, 0);
    drive_a(1, 32'h0000_000F, 0, 0); out_a("rst_c1", 1, 8, 8, 0, 0);
    ifa.in_valid = 0;
    #2 rst_n = 0;
    #1;
    out_a("rst_async", 0, 0, 0, 0, 0);
    chk("rst_in_ready", 32'(ifa.in_ready), 1);
    #2 rst_n = 1;
    tick();
    out_a("rst_nostale", 0, 0, 0, 0, 0);
    drive_a(1, 32'h0000_0003, 0, 1); out_a("rst_c2", 0, 0, 0, 0, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("rst_fresh", 1, 2, 2, 1, 0);
    drive_a(0, 32'h0, 0, 0);         out_a("rst_end", 0, 2, 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
